// File: rtl/alu_share_pkg.sv
// Shared types and ALU control encodings for the ALU share arbiter.
// ALU control macros stay guarded so a pre-existing ALU include takes precedence.
`ifndef ALUCTRL_WIRENUM
`define ALUCTRL_WIRENUM 4
`endif
`ifndef OP_NOP
`define OP_NOP 4'd0
`endif
`ifndef OP_ADD
`define OP_ADD 4'd1
`endif
`ifndef OP_SUB
`define OP_SUB 4'd2
`endif
`ifndef OP_AND
`define OP_AND 4'd3
`endif
`ifndef OP_OR
`define OP_OR 4'd4
`endif
`ifndef OP_XOR
`define OP_XOR 4'd5
`endif

package alu_share_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = `ALUCTRL_WIRENUM;

  localparam logic [ALU_CTRL_W-1:0] OP_NOP = `OP_NOP;
  localparam logic [ALU_CTRL_W-1:0] OP_ADD = `OP_ADD;
  localparam logic [ALU_CTRL_W-1:0] OP_SUB = `OP_SUB;
  localparam logic [ALU_CTRL_W-1:0] OP_AND = `OP_AND;
  localparam logic [ALU_CTRL_W-1:0] OP_OR  = `OP_OR;
  localparam logic [ALU_CTRL_W-1:0] OP_XOR = `OP_XOR;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } alu_share_state_t;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic                  id;
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  overflow;
    logic                  id;
  } alu_rsp_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_id is the only state.
// On a tie the requester not served last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);
  logic last_id;
  logic grant;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      valid0 & ~valid1: grant = 1'b0;
      valid1 & ~valid0: grant = 1'b1;
      valid0 & valid1:  grant = ~last_id;
      default:          grant = 1'b0;
    endcase
    ready0 = en & ~grant;
    ready1 = en & grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (valid0 & ready0) begin
      last_id <= 1'b0;
    end else if (valid1 & ready1) begin
      last_id <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: accept, execute for one cycle,
// then hold a tagged response until it is taken.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTRL_W = `ALUCTRL_WIRENUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow
);
  alu_share_state_t state, state_n;
  alu_op_t  op;
  alu_rsp_t rsp;
  logic     rsp_vld;
  logic     accept_ok;
  logic     acc0, acc1, accept;

  // rst_n in the window keeps both readies low during reset
  assign accept_ok = rst_n & ~flush &
    ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept_ok),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (req0_ready),
    .ready1 (req1_ready)
  );

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    alu_ctrl = OP_NOP;
    alu_a    = '0;
    alu_b    = '0;
    unique case (state)
      ST_IDLE: if (accept) state_n = ST_EXEC;
      ST_EXEC: begin
        state_n  = ST_RESP;
        alu_ctrl = op.ctrl;
        alu_a    = op.a;
        alu_b    = op.b;
      end
      ST_RESP: if (rsp_ready) state_n = accept ? ST_EXEC : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '{ctrl: OP_NOP, a: '0, b: '0, id: 1'b0};
    end else if (acc0) begin
      op <= '{req0_ctrl, req0_a, req0_b, 1'b0};
    end else if (acc1) begin
      op <= '{req1_ctrl, req1_a, req1_b, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp     <= '0;
      rsp_vld <= 1'b0;
    end else begin
      rsp_vld <= (state_n == ST_RESP);
      if ((state == ST_EXEC) & ~flush) begin
        rsp <= '{alu_result, alu_overflow, op.id};
      end
    end
  end

  assign rsp_valid    = rsp_vld;
  assign rsp_id       = rsp.id;
  assign rsp_result   = rsp.result;
  assign rsp_overflow = rsp.overflow;
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single ALU between two requesters, for example the pipeline EX stage and a multi-cycle mul/div or branch-compare unit. It accepts operations over valid/ready handshakes and drives the ALU control and operand inputs from registered state. It captures the ALU result and returns it to the issuing requester over a tagged response handshake. It sits between the requesters and the ALU; ALUCTRL encodings are the shared `OP_*` constants.

## Interface
- DATA_W, default 32: operand and result width.
- CTRL_W, default `ALUCTRL_WIRENUM: ALU control width.
- clk in 1: single clock; all state updates on the rising edge.
- rst_n in 1: reset, asynchronous assert, active-low.
- flush in 1: synchronous abort of the in-flight operation and any pending response.
- req0_valid in 1, req0_ready out 1, req0_ctrl in CTRL_W, req0_a in DATA_W, req0_b in DATA_W: requester 0.
- req1_valid in 1, req1_ready out 1, req1_ctrl in CTRL_W, req1_a in DATA_W, req1_b in DATA_W: requester 1.
- alu_ctrl out CTRL_W, alu_a out DATA_W, alu_b out DATA_W: drive the ALU.
- alu_result in DATA_W, alu_overflow in 1: combinational ALU outputs.
- rsp_valid out 1, rsp_ready in 1: response handshake.
- rsp_id out 1: index of the requester that issued the response.
- rsp_result out DATA_W, rsp_overflow out 1: response payload.

## Operation
- FSM states:
  - IDLE: no operation held.
  - EXEC: operands held; the ALU evaluates this cycle.
  - RESP: response held until accepted.
- Accept window: `accept_ok = (state==IDLE) | (state==RESP & rsp_ready)`, gated by `!flush`.
- Grant (combinational):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant `!last_id`.
  - `reqN_ready = accept_ok & grant==N`. The non-granted requester sees ready=0.
- Accept (`reqN_valid & reqN_ready`):
  - Latch ctrl, a, b and N into op registers.
  - Set `last_id = N`.
  - Next state is EXEC.
- EXEC:
  - `alu_ctrl`, `alu_a` and `alu_b` come from the op registers.
  - At the edge, capture `alu_result`, `alu_overflow` and the op id into the rsp registers.
  - Next state is RESP.
- RESP:
  - `rsp_valid=1`; payload stays stable until `rsp_ready`.
  - On `rsp_ready` with no accept, go to IDLE.
  - On `rsp_ready` with a same-cycle accept, go to EXEC (back-to-back).
- Outside EXEC: `alu_ctrl=OP_NOP`, `alu_a=alu_b=0`.
- Requester rules: payload must stay stable while valid=1 and ready=0. Valid may not drop before acceptance.
- Starvation bound: a requester holding valid is accepted within 2 accept windows.
- Requests with ctrl=OP_NOP are processed normally. The result is whatever the ALU returns.
- flush (priority over everything except reset):
  - Next state IDLE; rsp_valid=0 next cycle.
  - No accept that cycle, since ready=0 while flush=1.
  - last_id is unchanged.
- Reset values:
  - state IDLE, last_id=1 (req0 wins the first tie).
  - op registers 0, op ctrl `OP_NOP`.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0.
  - Outputs: alu_ctrl=OP_NOP, alu_a=alu_b=0, both readies=0 while rst_n=0.
- Reset asserted mid-operation discards the op and the response immediately (asynchronous).

## Timing
- Latency: accept at edge T gives EXEC in cycle T+1 and rsp_valid=1 from edge T+2.
- Throughput: one op per 2 cycles when rsp_ready is held high; otherwise limited by rsp_ready.
- Ready is combinational from state, rsp_ready, flush, the valids and last_id. There is no path from alu_result to any ready.
- ALU outputs are registered in the rsp stage; the ALU path budget is one full cycle (EXEC).
- rsp_* outputs come directly from registers.

## Structure
- Shared package `alu_share_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} alu_share_state_t`.
  - struct `alu_op_t` with fields ctrl, a, b, id.
  - struct `alu_rsp_t` with fields result, overflow, id.
- `OP_*` and `ALUCTRL_WIRENUM` come from the existing ALU macro include.
- One sub-module, `rr_arb2`: a 2-way round-robin grant from valids, last_id and an enable. Its only state is last_id, updated on accept.
- The top level holds the FSM, the op registers and the rsp registers.

## Test plan
- Single request: req0 with OP_ADD, a=5, b=7. Accepted in cycle 0; alu_ctrl=OP_ADD in cycle 1; rsp_valid=1, rsp_id=0, rsp_result=12 in cycle 2.
- Tie arbitration: after reset, both valid every cycle, rsp_ready=1. Accepts alternate 0,1,0,1 on cycles 0,2,4,6; rsp_id alternates likewise.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Payload stays stable, both readies stay 0, and alu_ctrl=OP_NOP throughout. When rsp_ready rises with req1 valid, req1 is accepted that same cycle.
- Flush: flush asserted during EXEC of req1 OP_SUB (9-4). No response appears; state returns to IDLE; the next req0 is accepted the cycle after flush drops.
- Async reset in RESP: rst_n low mid-cycle. rsp_valid=0 and alu_ctrl=OP_NOP immediately; after release, a tie grants req0 first.
- Overflow propagation: req0 OP_ADD with a=32'h7FFFFFFF, b=1 and the ALU model flagging overflow gives rsp_overflow=1, rsp_result=32'h80000000.
